spi_flash_target: RTL



---
 rtl/spi_flash_pkg.sv | 33 +++
 rtl/spi_flash_target_if.sv | 10 +
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_flash_target.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status bits and decoder states for the spi_flash
// initiator and the spi_flash_target responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_REMS  = 8'h90;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_RES   = 8'hAB;
    localparam logic [7:0] CMD_DP    = 8'hB9;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_SE    = 8'h20;
    localparam logic [7:0] CMD_PP    = 8'h02;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CMD  = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_SKIP = 3'd4;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s = 8'h00;
        s[SR_WEL] = wel;
        s[SR_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_target_if.sv
// SPI pin bundle between a flash initiator (master) and a responder (slave).
interface spi_flash_target_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_di;
    logic spi_do;

    modport master (output spi_clk, output spi_cs, output spi_di, input spi_do);
    modport slave  (input spi_clk, input spi_cs, input spi_di, output spi_do);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for SCK/CS/DI with SCK and CS edge pulses.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic cs_i,
    input  logic di_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic cs_o,
    output logic di_o
);
    logic [2:0] sck_q, sck_d;
    logic [2:0] cs_q, cs_d;
    logic [1:0] di_q, di_d;

    always_comb begin
        sck_d = {sck_q[1:0], sck_i};
        cs_d  = {cs_q[1:0], cs_i};
        di_d  = {di_q[0], di_i};
    end

    // SCK and CS idle high, so reset them high to avoid a false edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q <= '1;
            cs_q  <= '1;
            di_q  <= '0;
        end else begin
            sck_q <= sck_d;
            cs_q  <= cs_d;
            di_q  <= di_d;
        end
    end

    assign sck_rise_o = sck_q[1] & ~sck_q[2];
    assign sck_fall_o = ~sck_q[1] & sck_q[2];
    assign cs_rise_o  = cs_q[1] & ~cs_q[2];
    assign cs_fall_o  = ~cs_q[1] & cs_q[2];
    assign cs_o       = cs_q[1];
    assign di_o       = di_q[1];
endmodule

// File: rtl/spi_flash_target.sv
// SPI NOR flash responder serving a small internal array.
// Optional deep power-down: define SPI_FLASH_TARGET_POWERDOWN_EN.
module spi_flash_target #(
    parameter int          MEM_BYTES    = 1024,
    parameter int          SECTOR_BYTES = 256,
    parameter int          PROG_CYCLES  = 64,
    parameter int          ERASE_CYCLES = 1024,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
    parameter logic [15:0] DEV_ID       = 16'hEF15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    spi_flash_target_if.slave   spi,
    output logic                busy_o
);
    import spi_flash_pkg::*;

    localparam int AW = $clog2(MEM_BYTES);
    localparam int SW = $clog2(SECTOR_BYTES);
    localparam int ERASE_LEN = (SECTOR_BYTES > ERASE_CYCLES) ? SECTOR_BYTES : ERASE_CYCLES;
    localparam int CW = $clog2((ERASE_LEN > PROG_CYCLES) ? ERASE_LEN : PROG_CYCLES) + 1;

    logic sck_rise, sck_fall, cs_rise, cs_fall, cs_s, di_s, cs_low;

    spi_sync_edge u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sck_i      (spi.spi_clk),
        .cs_i       (spi.spi_cs),
        .di_i       (spi.spi_di),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall),
        .cs_o       (cs_s),
        .di_o       (di_s)
    );

    assign cs_low = ~cs_s;

    state_t        state_q, state_d;
    logic [4:0]    bit_q, bit_d;
    logic [6:0]    sh_q, sh_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    tx_q, tx_d;
    logic          do_q, do_d;
    logic [1:0]    idx_q, idx_d;
    logic          prog_seen_q, prog_seen_d;
    logic          erase_arm_q, erase_arm_d;
    logic          wel_q, wel_d;
    logic          wip_q, wip_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          erasing_q, erasing_d;
    logic [SW-1:0] eptr_q, eptr_d;
    logic [AW-1:0] ebase_q, ebase_d;
    logic          ld_q, ld_d;
    logic          pw_q, pw_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pd_w;

    // Array holds inverted bytes so a zero power-up image reads as 0xFF
    logic [7:0]    mem_q [MEM_BYTES];
    logic [7:0]    rdata_q;
    logic          re, we;
    logic [AW-1:0] raddr, waddr;
    logic [7:0]    wdata;

    logic [7:0]    op_w;
    logic [23:0]   addr_w;
    logic [7:0]    status_w;

    assign op_w     = {sh_q, di_s};
    assign addr_w   = {addr_q[22:0], di_s};
    assign status_w = status_byte(wel_q, wip_q);

`ifdef SPI_FLASH_TARGET_POWERDOWN_EN
    logic pd_q, pd_d;
    assign pd_w = pd_q;

    always_comb begin
        pd_d = pd_q;
        if (cs_rise && state_q == ST_DATA) begin
            if (cmd_q == CMD_DP)  pd_d = 1'b1;
            if (cmd_q == CMD_RES) pd_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pd_q <= 1'b0;
        else         pd_q <= pd_d;
    end
`else
    assign pd_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        do_d        = do_q;
        idx_d       = idx_q;
        prog_seen_d = prog_seen_q;
        erase_arm_d = erase_arm_q;
        wel_d       = wel_q;
        wip_d       = wip_q;
        cnt_d       = cnt_q;
        erasing_d   = erasing_q;
        eptr_d      = eptr_q;
        ebase_d     = ebase_q;
        ld_d        = 1'b0;
        pw_d        = 1'b0;
        pbyte_d     = pbyte_q;
        paddr_d     = paddr_q;
        re          = 1'b0;
        raddr       = addr_q[AW-1:0];
        we          = 1'b0;
        waddr       = paddr_q;
        wdata       = rdata_q | ~pbyte_q;

        if (wip_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) wip_d = 1'b0;
        end
        if (erasing_q) begin
            we     = 1'b1;
            waddr  = ebase_q | AW'(eptr_q);
            wdata  = 8'h00;
            eptr_d = eptr_q + SW'(1);
            if (eptr_q == '1) erasing_d = 1'b0;
        end
        if (pw_q) begin
            we    = 1'b1;
            waddr = paddr_q;
            wdata = rdata_q | ~pbyte_q;
        end
        if (ld_q) tx_d = ~rdata_q;

        if (sck_fall && cs_low) begin
            do_d = tx_q[7];
            tx_d = {tx_q[6:0], 1'b0};
        end

        if (cs_rise) begin
            if (state_q == ST_DATA) begin
                case (cmd_q)
                    CMD_WREN: wel_d = 1'b1;
                    CMD_PP: if (prog_seen_q) begin
                        wel_d = 1'b0;
                        wip_d = 1'b1;
                        cnt_d = CW'(PROG_CYCLES);
                    end
                    CMD_SE: if (erase_arm_q) begin
                        wel_d     = 1'b0;
                        wip_d     = 1'b1;
                        cnt_d     = CW'(ERASE_LEN);
                        erasing_d = 1'b1;
                        eptr_d    = '0;
                        ebase_d   = addr_q[AW-1:0] & ~AW'(SECTOR_BYTES - 1);
                    end
                    default: ;
                endcase
            end
            state_d = ST_IDLE;
            tx_d    = 8'h00;
            do_d    = 1'b0;
        end else if (cs_fall) begin
            state_d     = ST_CMD;
            bit_d       = '0;
            tx_d        = 8'h00;
            do_d        = 1'b0;
            idx_d       = '0;
            prog_seen_d = 1'b0;
            erase_arm_d = 1'b0;
        end else if (sck_rise && cs_low) begin
            sh_d  = {sh_q[5:0], di_s};
            bit_d = bit_q + 5'd1;
            case (state_q)
                ST_CMD: if (bit_q == 5'd7) begin
                    bit_d = '0;
                    cmd_d = op_w;
                    if (pd_w) begin
                        state_d = (op_w == CMD_RES) ? ST_DATA : ST_SKIP;
                    end else if (wip_q && op_w != CMD_RDSR) begin
                        state_d = ST_SKIP;
                    end else begin
                        case (op_w)
                            CMD_RDSR: begin
                                state_d = ST_DATA;
                                tx_d    = status_w;
                            end
                            CMD_READ, CMD_REMS: state_d = ST_ADDR;
                            CMD_PP, CMD_SE: state_d = wel_q ? ST_ADDR : ST_SKIP;
                            CMD_JEDEC: begin
                                state_d = ST_DATA;
                                tx_d    = JEDEC_ID[23:16];
                                idx_d   = 2'd1;
                            end
                            CMD_WREN, CMD_DP, CMD_RES: state_d = ST_DATA;
                            default: state_d = ST_SKIP;
                        endcase
                    end
                end
                ST_ADDR: begin
                    addr_d = addr_w;
                    if (bit_q == 5'd23) begin
                        bit_d   = '0;
                        state_d = ST_DATA;
                        case (cmd_q)
                            CMD_READ: begin
                                re     = 1'b1;
                                raddr  = addr_w[AW-1:0];
                                ld_d   = 1'b1;
                                addr_d = addr_w + 24'd1;
                            end
                            CMD_REMS: begin
                                tx_d  = DEV_ID[15:8];
                                idx_d = 2'd1;
                            end
                            CMD_SE: erase_arm_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_DATA: begin
                    // any bit past the address disqualifies a sector erase
                    if (cmd_q == CMD_SE) erase_arm_d = 1'b0;
                    if (bit_q[2:0] == 3'd7) begin
                        case (cmd_q)
                            CMD_RDSR: tx_d = status_w;
                            CMD_READ: begin
                                re     = 1'b1;
                                ld_d   = 1'b1;
                                addr_d = addr_q + 24'd1;
                            end
                            CMD_JEDEC: begin
                                case (idx_q)
                                    2'd1:    tx_d = JEDEC_ID[15:8];
                                    2'd2:    tx_d = JEDEC_ID[7:0];
                                    default: tx_d = 8'h00;
                                endcase
                                if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
                            end
                            CMD_REMS: begin
                                tx_d  = idx_q[0] ? DEV_ID[7:0] : DEV_ID[15:8];
                                idx_d = {1'b0, ~idx_q[0]};
                            end
                            CMD_PP: begin
                                re          = 1'b1;
                                pw_d        = 1'b1;
                                pbyte_d     = op_w;
                                paddr_d     = addr_q[AW-1:0];
                                prog_seen_d = 1'b1;
                                addr_d      = {addr_q[23:8], addr_q[7:0] + 8'd1};
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            sh_q        <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            do_q        <= 1'b0;
            idx_q       <= '0;
            prog_seen_q <= 1'b0;
            erase_arm_q <= 1'b0;
            wel_q       <= 1'b0;
            wip_q       <= 1'b0;
            cnt_q       <= '0;
            erasing_q   <= 1'b0;
            eptr_q      <= '0;
            ebase_q     <= '0;
            ld_q        <= 1'b0;
            pw_q        <= 1'b0;
            pbyte_q     <= '0;
            paddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            do_q        <= do_d;
            idx_q       <= idx_d;
            prog_seen_q <= prog_seen_d;
            erase_arm_q <= erase_arm_d;
            wel_q       <= wel_d;
            wip_q       <= wip_d;
            cnt_q       <= cnt_d;
            erasing_q   <= erasing_d;
            eptr_q      <= eptr_d;
            ebase_q     <= ebase_d;
            ld_q        <= ld_d;
            pw_q        <= pw_d;
            pbyte_q     <= pbyte_d;
            paddr_q     <= paddr_d;
        end
    end

    assign spi.spi_do = do_q;
    assign busy_o     = wip_q;
endmodule
